// File: rtl/inference_sequencer_if.sv
// Bundles the host, datapath and result signals of the inference sequencer.
// master = host/datapath side, slave = sequencer side.
interface inference_sequencer_if #(
  parameter int NSTG = 5,
  parameter int CW   = 16
);
  logic            weights_ready;
  logic            kernel_in_valid;
  logic            kernel_wr_en;
  logic            kernel_wr_reject;
  logic            image_in_valid;
  logic            image_in_ready;
  logic            image_load;
  logic [NSTG-1:0] stage_start;
  logic [NSTG-1:0] stage_done;
  logic [NSTG-1:0] stage_busy;
  logic [3:0]      class_in;
  logic [3:0]      class_out;
  logic            class_out_valid;
  logic            class_out_ready;
  logic            err_timeout;
  logic [2:0]      err_stage;
  logic            err_clear;
  logic [CW-1:0]   last_latency;

  modport master (
    output weights_ready, kernel_in_valid, image_in_valid, stage_done,
           class_in, class_out_ready, err_clear,
    input  kernel_wr_en, kernel_wr_reject, image_in_ready, image_load,
           stage_start, stage_busy, class_out, class_out_valid,
           err_timeout, err_stage, last_latency
  );

  modport slave (
    input  weights_ready, kernel_in_valid, image_in_valid, stage_done,
           class_in, class_out_ready, err_clear,
    output kernel_wr_en, kernel_wr_reject, image_in_ready, image_load,
           stage_start, stage_busy, class_out, class_out_valid,
           err_timeout, err_stage, last_latency
  );
endinterface

// File: rtl/inference_sequencer.sv
// Inference sequencer: accepts an image, walks the datapath stages one at a
// time with start/done handshakes, guards each stage with a timeout, and
// presents the argmax class with a valid/ready handshake.
module inference_sequencer #(
  parameter int NSTG    = 5,
  parameter int TIMEOUT = 4096,
  parameter int CW      = 16
) (
  input logic                  clk,
  input logic                  rst,
  inference_sequencer_if.slave bus
);

  localparam int KW = (NSTG > 1) ? $clog2(NSTG) : 1;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_WAIT_IMG = 3'd1;
  localparam logic [2:0] S_RUN      = 3'd2;
  localparam logic [2:0] S_WAIT_OUT = 3'd3;
  localparam logic [2:0] S_ERR      = 3'd4;

  // The stage's (TIMEOUT-1)th cycle is the last one allowed to deliver done;
  // the counter reads TIMEOUT-2 in that cycle.
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 2);
  localparam logic [KW-1:0] K_LAST   = KW'(NSTG - 1);

  logic [2:0]      r_state;
  logic [KW-1:0]   r_k;
  logic [CW-1:0]   r_lat;
  logic [CW-1:0]   r_tmo;
  logic            r_image_in_ready;
  logic [NSTG-1:0] r_stage_start;
  logic [NSTG-1:0] r_stage_busy;
  logic [3:0]      r_class_out;
  logic            r_class_out_valid;
  logic            r_err_timeout;
  logic [2:0]      r_err_stage;
  logic [CW-1:0]   r_last_latency;

  logic            w_img_hs;
  logic            w_in_start;
  logic            w_done_acc;
  logic            w_tmo_hit;
  logic            w_kernel_open;
  logic [CW-1:0]   w_lat_inc;
  logic [NSTG-1:0] w_stage_next;

  assign w_img_hs      = bus.image_in_valid & r_image_in_ready;
  // A done pulse in the same cycle as its start pulse is stale and ignored.
  assign w_in_start    = |r_stage_start;
  assign w_done_acc    = (r_state == S_RUN) & ~w_in_start & bus.stage_done[r_k];
  assign w_tmo_hit     = (r_tmo == TMO_LAST);
  assign w_lat_inc     = (r_lat == {CW{1'b1}}) ? r_lat : r_lat + CW'(1);
  assign w_stage_next  = NSTG'(1) << (r_k + KW'(1));
  assign w_kernel_open = (r_state == S_IDLE) | (r_state == S_WAIT_IMG);

  assign bus.kernel_wr_en     = bus.kernel_in_valid & w_kernel_open;
  assign bus.kernel_wr_reject = bus.kernel_in_valid & ~w_kernel_open;
  assign bus.image_load       = w_img_hs;
  assign bus.image_in_ready   = r_image_in_ready;
  assign bus.stage_start      = r_stage_start;
  assign bus.stage_busy       = r_stage_busy;
  assign bus.class_out        = r_class_out;
  assign bus.class_out_valid  = r_class_out_valid;
  assign bus.err_timeout      = r_err_timeout;
  assign bus.err_stage        = r_err_stage;
  assign bus.last_latency     = r_last_latency;

  // Sequencer FSM with all registered outputs updated alongside the state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state           <= S_IDLE;
      r_k               <= '0;
      r_lat             <= '0;
      r_tmo             <= '0;
      r_image_in_ready  <= 1'b0;
      r_stage_start     <= '0;
      r_stage_busy      <= '0;
      r_class_out       <= '0;
      r_class_out_valid <= 1'b0;
      r_err_timeout     <= 1'b0;
      r_err_stage       <= '0;
      r_last_latency    <= '0;
    end else begin
      r_stage_start <= '0;
      case (r_state)
        S_IDLE: begin
          if (bus.weights_ready) begin
            r_state          <= S_WAIT_IMG;
            r_image_in_ready <= 1'b1;
          end
        end
        S_WAIT_IMG: begin
          // An offered image has already been written, so it wins over
          // weights_ready dropping in the same cycle.
          if (w_img_hs) begin
            r_state          <= S_RUN;
            r_image_in_ready <= 1'b0;
            r_k              <= '0;
            r_stage_start    <= NSTG'(1);
            r_stage_busy     <= NSTG'(1);
            r_lat            <= '0;
            r_tmo            <= '0;
          end else if (!bus.weights_ready) begin
            r_state          <= S_IDLE;
            r_image_in_ready <= 1'b0;
          end
        end
        S_RUN: begin
          r_lat <= w_lat_inc;
          if (w_done_acc) begin
            if (r_k == K_LAST) begin
              r_state           <= S_WAIT_OUT;
              r_class_out       <= bus.class_in;
              r_class_out_valid <= 1'b1;
              r_last_latency    <= w_lat_inc;
              r_stage_busy      <= '0;
            end else begin
              r_k           <= r_k + KW'(1);
              r_stage_start <= w_stage_next;
              r_stage_busy  <= w_stage_next;
              r_tmo         <= '0;
            end
          end else if (w_tmo_hit) begin
            r_state       <= S_ERR;
            r_err_timeout <= 1'b1;
            r_err_stage   <= 3'(r_k);
            r_stage_busy  <= '0;
          end else begin
            r_tmo <= r_tmo + CW'(1);
          end
        end
        S_WAIT_OUT: begin
          if (bus.class_out_ready) begin
            r_state           <= S_WAIT_IMG;
            r_class_out_valid <= 1'b0;
            r_image_in_ready  <= 1'b1;
          end
        end
        S_ERR: begin
          if (bus.err_clear) begin
            r_state       <= S_IDLE;
            r_err_timeout <= 1'b0;
            r_err_stage   <= '0;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inference_sequencer.sv
// Testbench for inference_sequencer: directed phases with randomized stage
// delays, classes, side-band noise and backpressure, checked against
// expectations derived from the stage timing rules.
module tb_inference_sequencer;

  localparam int NS  = 5;
  localparam int TMO = 16;
  localparam int CWT = 16;

  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  inference_sequencer_if #(.NSTG(NS), .CW(CWT)) bus ();

  inference_sequencer #(.NSTG(NS), .TIMEOUT(TMO), .CW(CWT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Random done bits for every stage except k (those must be ignored).
  function automatic logic [NS-1:0] noise(input int k);
    logic [NS-1:0] m;
    m = NS'(1) << k;
    return NS'($urandom) & ~m;
  endfunction

  // Entered in a WAIT_IMG cycle; returns in the first cycle of stage 0.
  task automatic handshake();
    chk("image_in_ready_wait", bus.image_in_ready, 1);
    bus.kernel_in_valid = 1'b1;
    #1;
    chk("kernel_wr_en_wait", bus.kernel_wr_en, 1);
    chk("kernel_wr_reject_wait", bus.kernel_wr_reject, 0);
    bus.kernel_in_valid = 1'b0;
    bus.image_in_valid  = 1'b1;
    #1;
    chk("image_load_hs", bus.image_load, 1);
    step();
    #1;
    chk("image_load_after_hs", bus.image_load, 0);
    bus.image_in_valid = 1'b0;
  endtask

  // Stage k takes d+1 cycles: its start cycle plus done arriving d cycles later.
  task automatic drive_stage(input int k, input int d, input logic [3:0] cls, input bit toggle_wr);
    logic [NS-1:0] onehot;
    onehot = NS'(1) << k;
    chk($sformatf("stage_start_pulse_k%0d", k), bus.stage_start, onehot);
    chk($sformatf("stage_busy_k%0d", k), bus.stage_busy, onehot);
    chk("err_timeout_run", bus.err_timeout, 0);
    chk("image_in_ready_run", bus.image_in_ready, 0);
    chk("class_out_valid_run", bus.class_out_valid, 0);
    bus.stage_done = onehot | noise(k);
    bus.class_in   = 4'($urandom);
    for (int c = 1; c <= d; c++) begin
      step();
      chk("stage_start_clear", bus.stage_start, 0);
      chk("stage_busy_hold", bus.stage_busy, onehot);
      bus.kernel_in_valid = 1'b1;
      bus.image_in_valid  = 1'b1;
      #1;
      chk("kernel_wr_en_run", bus.kernel_wr_en, 0);
      chk("kernel_wr_reject_run", bus.kernel_wr_reject, 1);
      chk("image_load_run", bus.image_load, 0);
      bus.kernel_in_valid = 1'b0;
      bus.image_in_valid  = 1'b0;
      bus.stage_done = noise(k) | ((c == d) ? onehot : NS'(0));
      bus.class_in   = (c == d) ? cls : 4'($urandom);
      if (toggle_wr) bus.weights_ready = 1'($urandom);
    end
    step();
    bus.stage_done = '0;
  endtask

  // Full inference from WAIT_IMG back to WAIT_IMG (or IDLE and back).
  task automatic run_inf(input int dl[NS], input logic [3:0] cls, input int hold, input bit toggle_wr);
    int lat;
    lat = 0;
    handshake();
    for (int k = 0; k < NS; k++) begin
      drive_stage(k, dl[k], cls, toggle_wr);
      lat += dl[k] + 1;
    end
    if (toggle_wr) bus.weights_ready = 1'b0;
    chk("class_out_valid_set", bus.class_out_valid, 1);
    chk("class_out", bus.class_out, cls);
    chk("last_latency", bus.last_latency, lat);
    chk("stage_busy_out", bus.stage_busy, 0);
    chk("stage_start_out", bus.stage_start, 0);
    for (int i = 0; i < hold; i++) begin
      bus.class_out_ready = 1'b0;
      step();
      chk("class_out_valid_hold", bus.class_out_valid, 1);
      chk("class_out_hold", bus.class_out, cls);
      chk("image_in_ready_hold", bus.image_in_ready, 0);
    end
    bus.class_out_ready = 1'b1;
    step();
    bus.class_out_ready = 1'b0;
    chk("class_out_valid_clear", bus.class_out_valid, 0);
    chk("image_in_ready_after_out", bus.image_in_ready, 1);
    if (toggle_wr) begin
      step();
      chk("image_in_ready_to_idle", bus.image_in_ready, 0);
      bus.weights_ready = 1'b1;
      step();
      chk("image_in_ready_rearm", bus.image_in_ready, 1);
    end
    $display("inference class=%0d latency=%0d hold=%0d", cls, lat, hold);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_stage_start"}, bus.stage_start, 0);
    chk({tag, "_stage_busy"}, bus.stage_busy, 0);
    chk({tag, "_image_in_ready"}, bus.image_in_ready, 0);
    chk({tag, "_class_out_valid"}, bus.class_out_valid, 0);
    chk({tag, "_class_out"}, bus.class_out, 0);
    chk({tag, "_err_timeout"}, bus.err_timeout, 0);
    chk({tag, "_err_stage"}, bus.err_stage, 0);
    chk({tag, "_last_latency"}, bus.last_latency, 0);
  endtask

  initial begin
    int dl[NS];
    int nom[NS];
    logic [3:0] cls;

    rst                 = 1'b0;
    bus.weights_ready   = 1'b0;
    bus.kernel_in_valid = 1'b0;
    bus.image_in_valid  = 1'b0;
    bus.stage_done      = '0;
    bus.class_in        = '0;
    bus.class_out_ready = 1'b0;
    bus.err_clear       = 1'b0;
    for (int k = 0; k < NS; k++) nom[k] = 3;

    // Reset state
    repeat (3) step();
    chk_all_zero("reset");
    chk("kernel_wr_en_reset", bus.kernel_wr_en, 0);
    rst = 1'b1;
    step();
    chk("idle_no_weights", bus.image_in_ready, 0);
    bus.kernel_in_valid = 1'b1;
    #1;
    chk("kernel_wr_en_idle", bus.kernel_wr_en, 1);
    chk("kernel_wr_reject_idle", bus.kernel_wr_reject, 0);
    bus.kernel_in_valid = 1'b0;
    bus.weights_ready   = 1'b1;
    step();
    $display("reset and idle phase done");

    // Nominal run with 10 cycles of output backpressure
    run_inf(nom, 4'd7, 10, 1'b0);

    // Randomized runs; one drops weights_ready while busy
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < NS; k++) dl[k] = $urandom_range(1, TMO - 2);
      cls = 4'($urandom);
      run_inf(dl, cls, $urandom_range(0, 4), (r == 1));
    end

    // Timeout: stage 1 finishes in its last allowed cycle, stage 2 never does
    handshake();
    drive_stage(0, 1, 4'd0, 1'b0);
    drive_stage(1, TMO - 2, 4'd0, 1'b0);
    chk("stage_start_k2_tmo", bus.stage_start, 5'b00100);
    bus.stage_done = 5'b00100;
    for (int c = 1; c < TMO - 1; c++) begin
      step();
      bus.stage_done = noise(2);
      chk("err_timeout_pending", bus.err_timeout, 0);
      chk("stage_busy_pending", bus.stage_busy, 5'b00100);
    end
    step();
    bus.stage_done = '0;
    chk("err_timeout_set", bus.err_timeout, 1);
    chk("err_stage_set", bus.err_stage, 2);
    chk("stage_busy_err", bus.stage_busy, 0);
    chk("stage_start_err", bus.stage_start, 0);
    chk("image_in_ready_err", bus.image_in_ready, 0);
    step();
    chk("err_timeout_sticky", bus.err_timeout, 1);
    bus.err_clear = 1'b1;
    step();
    bus.err_clear = 1'b0;
    chk("err_timeout_clear", bus.err_timeout, 0);
    chk("err_stage_clear", bus.err_stage, 0);
    chk("image_in_ready_idle_after_err", bus.image_in_ready, 0);
    step();
    $display("timeout phase done");

    // Reset in the middle of stage 3, then a clean rerun
    handshake();
    for (int k = 0; k < 3; k++) drive_stage(k, 3, 4'd0, 1'b0);
    step();
    step();
    rst = 1'b0;
    step();
    rst = 1'b1;
    chk_all_zero("midrun_reset");
    for (int i = 0; i < 3; i++) begin
      step();
      chk("no_start_after_reset", bus.stage_start, 0);
      chk("no_busy_after_reset", bus.stage_busy, 0);
    end
    $display("mid-run reset phase done");
    run_inf(nom, 4'd7, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
